// File: rtl/nios2_oci_dct_pkg.sv
// nios2_oci_dct_pkg
//   Shared constants and types for the OCI debug-compression-trace packer:
//   atom/word geometry, the 2-bit trace atom encoding and the packer
//   state machine encoding.
package nios2_oci_dct_pkg;

   localparam int unsigned ATOM_W         = 2;
   localparam int unsigned ATOMS_PER_WORD = 15;
   localparam int unsigned BUF_W          = ATOM_W * ATOMS_PER_WORD;
   localparam int unsigned CNT_W          = 4;

   // Slot index of the last atom in a word; an accept here completes it.
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(ATOMS_PER_WORD - 1);

   typedef enum logic [ATOM_W-1:0] {
      ATOM_NOP       = 2'b00,
      ATOM_TAKEN     = 2'b01,
      ATOM_NOT_TAKEN = 2'b10,
      ATOM_EXCEPTION = 2'b11
   } atom_e;

   typedef enum logic [1:0] {
      FILL,
      DRAIN,
      DONE
   } state_e;

endpackage

// File: rtl/nios2_oci_dct_outreg.sv
// nios2_oci_dct_outreg
//   One-entry valid/ready holding register for a packed word and its atom
//   count. A load may coincide with the downstream handshake of the word
//   currently held (pass-through), so free is high when empty or draining.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   load                capture load_data/load_count (only when free)
//   load_data/count     word and atom count to capture
//   ready               downstream accepts the held word
//   valid/data/count    held word towards downstream
//   free                a load is allowed this cycle
module nios2_oci_dct_outreg
   import nios2_oci_dct_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [BUF_W-1:0] load_data,
   input  logic [CNT_W-1:0] load_count,
   input  logic             ready,
   output logic             valid,
   output logic [BUF_W-1:0] data,
   output logic [CNT_W-1:0] count,
   output logic             free
);

   assign free = !valid || ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= 1'b0;
         data  <= '0;
         count <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         count <= load_count;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/nios2_nios2_qsys_0_oci_dct_packer.sv
// nios2_nios2_qsys_0_oci_dct_packer
//   Packs 2-bit trace atoms (atom 0 at the LSBs) into 30-bit words of 15
//   atoms and hands full or flushed partial words downstream over
//   valid/ready. Owns the test_ending -> test_has_ended drain sequence.
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   atom_valid/atom/atom_ready atom input handshake
//   flush                      pulse: emit the partial word
//   test_ending                level: stop accepting, drain, then report
//   dct_buffer/dct_count       live packing register and its atom count
//   out_valid/out_data/out_count/out_ready  packed word output
//   stall_cnt                  saturating atom stall counter (only with
//                              OCI_DCT_STALL_CNT_EN defined)
//   test_has_ended             sticky drain-complete flag
module nios2_nios2_qsys_0_oci_dct_packer
   import nios2_oci_dct_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              atom_valid,
   input  logic [ATOM_W-1:0] atom,
   output logic              atom_ready,
   input  logic              flush,
   input  logic              test_ending,
   output logic [BUF_W-1:0]  dct_buffer,
   output logic [CNT_W-1:0]  dct_count,
   output logic              out_valid,
   output logic [BUF_W-1:0]  out_data,
   output logic [CNT_W-1:0]  out_count,
   input  logic              out_ready,
`ifdef OCI_DCT_STALL_CNT_EN
   output logic [15:0]       stall_cnt,
`endif
   output logic              test_has_ended
);

   state_e           state, next_state;
   atom_e            atom_code;
   logic             flush_pend, next_flush_pend;
   logic             ending, out_free, accept, complete, fire_flush, emit;
   logic [BUF_W-1:0] next_buf;
   logic [CNT_W-1:0] next_cnt;

   assign atom_code      = atom_e'(atom);
   assign ending         = (state != FILL);
   assign test_has_ended = (state == DONE);

   nios2_oci_dct_outreg u_outreg (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (emit),
      .load_data  (next_buf),
      .load_count (next_cnt),
      .ready      (out_ready),
      .valid      (out_valid),
      .data       (out_data),
      .count      (out_count),
      .free       (out_free)
   );

   always_comb begin
      atom_ready = !ending && ((dct_count != LAST_SLOT) || out_free);
      accept     = atom_valid && atom_ready;
      complete   = accept && (dct_count == LAST_SLOT);
      fire_flush = flush_pend && out_free;
      next_cnt   = dct_count + CNT_W'(accept);
      next_buf   = dct_buffer;
      for (int unsigned i = 0; i < ATOMS_PER_WORD; i++) begin
         if (accept && (dct_count == CNT_W'(i)))
            next_buf[i*ATOM_W +: ATOM_W] = atom_code;
      end
      // A flush that finds nothing packed (and nothing arriving) emits no word.
      emit = complete || (fire_flush && (next_cnt != '0));
      // A pending flush absorbs further flush/test_ending requests until it fires.
      if (flush_pend)
         next_flush_pend = !out_free;
      else
         next_flush_pend = flush || (test_ending && !ending);
   end

   always_comb begin
      next_state = state;
      unique case (state)
         FILL:    if (test_ending) next_state = DRAIN;
         DRAIN:   if ((dct_count == '0) && !flush_pend && !out_valid)
                     next_state = DONE;
         DONE:    next_state = DONE;
         default: next_state = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= FILL;
         flush_pend <= 1'b0;
         dct_buffer <= '0;
         dct_count  <= '0;
      end else begin
         state      <= next_state;
         flush_pend <= next_flush_pend;
         if (emit || fire_flush) begin
            dct_buffer <= '0;
            dct_count  <= '0;
         end else begin
            dct_buffer <= next_buf;
            dct_count  <= next_cnt;
         end
      end
   end

`ifdef OCI_DCT_STALL_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         stall_cnt <= '0;
      else if (atom_valid && !atom_ready && !ending && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_nios2_nios2_qsys_0_oci_dct_packer.sv
// tb_nios2_nios2_qsys_0_oci_dct_packer
//   Directed self-checking bench for the DCT packer. Inputs change 1 ns
//   after the rising edge; outputs are checked at that point or later.
module tb_nios2_nios2_qsys_0_oci_dct_packer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        atom_valid;
   logic [1:0]  atom;
   logic        atom_ready;
   logic        flush;
   logic        test_ending;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        out_valid;
   logic [29:0] out_data;
   logic [3:0]  out_count;
   logic        out_ready;
   logic        test_has_ended;
`ifdef OCI_DCT_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   nios2_nios2_qsys_0_oci_dct_packer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .atom_valid     (atom_valid),
      .atom           (atom),
      .atom_ready     (atom_ready),
      .flush          (flush),
      .test_ending    (test_ending),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_count      (out_count),
      .out_ready      (out_ready),
`ifdef OCI_DCT_STALL_CNT_EN
      .stall_cnt      (stall_cnt),
`endif
      .test_has_ended (test_has_ended)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] a);
      atom_valid = 1'b1;
      atom       = a;
      tick();
   endtask

   initial begin
      reset_n     = 1'b0;
      atom_valid  = 1'b0;
      atom        = 2'b00;
      flush       = 1'b0;
      test_ending = 1'b0;
      out_ready   = 1'b1;
      tick();
      tick();
      chk("rst_dct_buffer", 32'(dct_buffer), 32'h0);
      chk("rst_dct_count", 32'(dct_count), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_out_count", 32'(out_count), 32'h0);
      chk("rst_test_has_ended", 32'(test_has_ended), 32'h0);
      reset_n = 1'b1;
      tick();

      // Full word of TAKEN atoms.
      for (int i = 0; i < 14; i++) send(2'b01);
      chk("full_count14", 32'(dct_count), 32'd14);
      send(2'b01);
      atom_valid = 1'b0;
      chk("full_out_valid", 32'(out_valid), 32'h1);
      chk("full_out_data", 32'(out_data), 32'h15555555);
      chk("full_out_count", 32'(out_count), 32'd15);
      chk("full_dct_count", 32'(dct_count), 32'd0);
      tick();
      chk("full_handshake", 32'(out_valid), 32'h0);

      // Partial flush of three atoms, then an empty flush.
      send(2'b11);
      send(2'b10);
      send(2'b01);
      atom_valid = 1'b0;
      flush      = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_pend_count", 32'(dct_count), 32'd3);
      chk("flush_pend_buffer", 32'(dct_buffer), 32'h1B);
      tick();
      chk("flush_out_valid", 32'(out_valid), 32'h1);
      chk("flush_out_data", 32'(out_data), 32'h0000001B);
      chk("flush_out_count", 32'(out_count), 32'd3);
      chk("flush_dct_count", 32'(dct_count), 32'd0);
      tick();
      chk("flush_handshake", 32'(out_valid), 32'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("empty_flush_a", 32'(out_valid), 32'h0);
      tick();
      chk("empty_flush_b", 32'(out_valid), 32'h0);
      tick();
      chk("empty_flush_c", 32'(out_valid), 32'h0);

      // Backpressure: held word plus 14 packed atoms stalls the 15th.
      out_ready = 1'b0;
      for (int i = 0; i < 15; i++) send(2'b10);
      chk("bp_held_valid", 32'(out_valid), 32'h1);
      chk("bp_held_data", 32'(out_data), 32'h2AAAAAAA);
      for (int i = 0; i < 14; i++) send(2'b11);
      chk("bp_count14", 32'(dct_count), 32'd14);
      atom_valid = 1'b1;
      atom       = 2'b01;
      #1;
      chk("bp_atom_ready_low", 32'(atom_ready), 32'h0);
      tick();
      chk("bp_still_held", 32'(out_data), 32'h2AAAAAAA);
      chk("bp_still_count14", 32'(dct_count), 32'd14);
      out_ready = 1'b1;
      #1;
      chk("bp_atom_ready_high", 32'(atom_ready), 32'h1);
      tick();
      atom_valid = 1'b0;
      chk("bp_new_valid", 32'(out_valid), 32'h1);
      chk("bp_new_data", 32'(out_data), 32'h1FFFFFFF);
      chk("bp_new_count", 32'(out_count), 32'd15);
      chk("bp_dct_count", 32'(dct_count), 32'd0);
      tick();
      chk("bp_handshake", 32'(out_valid), 32'h0);

      // End-of-test drain with an atom in the test_ending cycle.
      for (int i = 0; i < 5; i++) send(2'b01);
      atom_valid  = 1'b1;
      atom        = 2'b10;
      test_ending = 1'b1;
      #1;
      chk("end_first_ready", 32'(atom_ready), 32'h1);
      tick();
      atom = 2'b11;
      #1;
      chk("end_ready_low", 32'(atom_ready), 32'h0);
      chk("end_count6", 32'(dct_count), 32'd6);
      tick();
      chk("end_out_valid", 32'(out_valid), 32'h1);
      chk("end_out_data", 32'(out_data), 32'h00000955);
      chk("end_out_count", 32'(out_count), 32'd6);
      chk("end_not_ended_a", 32'(test_has_ended), 32'h0);
      tick();
      chk("end_handshake", 32'(out_valid), 32'h0);
      chk("end_not_ended_b", 32'(test_has_ended), 32'h0);
      tick();
      chk("end_has_ended", 32'(test_has_ended), 32'h1);
      test_ending = 1'b0;
      atom_valid  = 1'b0;
      tick();
      chk("end_sticky", 32'(test_has_ended), 32'h1);
      chk("end_ready_stays_low", 32'(atom_ready), 32'h0);

      // Asynchronous reset mid-word with a held output.
      reset_n = 1'b0;
      tick();
      reset_n   = 1'b1;
      out_ready = 1'b0;
      tick();
      for (int i = 0; i < 15; i++) send(2'b01);
      for (int i = 0; i < 7; i++) send(2'b11);
      atom_valid = 1'b0;
      chk("ar_pre_count", 32'(dct_count), 32'd7);
      chk("ar_pre_valid", 32'(out_valid), 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar_dct_count", 32'(dct_count), 32'h0);
      chk("ar_dct_buffer", 32'(dct_buffer), 32'h0);
      chk("ar_out_valid", 32'(out_valid), 32'h0);
      chk("ar_out_data", 32'(out_data), 32'h0);
      chk("ar_out_count", 32'(out_count), 32'h0);
      chk("ar_has_ended", 32'(test_has_ended), 32'h0);
      tick();
      reset_n   = 1'b1;
      out_ready = 1'b1;
      tick();
      for (int i = 0; i < 15; i++) send(2'b11);
      atom_valid = 1'b0;
      chk("ar_clean_valid", 32'(out_valid), 32'h1);
      chk("ar_clean_data", 32'(out_data), 32'h3FFFFFFF);
      chk("ar_clean_count", 32'(out_count), 32'd15);
      tick();

`ifdef OCI_DCT_STALL_CNT_EN
      // Stall counter: 20 stalls, then saturation.
      reset_n = 1'b0;
      tick();
      reset_n   = 1'b1;
      out_ready = 1'b0;
      tick();
      for (int i = 0; i < 15; i++) send(2'b01);
      for (int i = 0; i < 14; i++) send(2'b01);
      chk("stall_zero", 32'(stall_cnt), 32'd0);
      for (int i = 0; i < 20; i++) send(2'b01);
      chk("stall_20", 32'(stall_cnt), 32'd20);
      for (int i = 0; i < 70000; i++) send(2'b01);
      chk("stall_sat", 32'(stall_cnt), 32'h0000FFFF);
      atom_valid = 1'b0;
      out_ready  = 1'b1;
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nios2_nios2_qsys_0_oci_dct_packer.md
Name: nios2_nios2_qsys_0_oci_dct_packer

Overview:
Upstream packer for the OCI debug-compression-trace (DCT) path. Packs 2-bit trace atoms from the OCI trace logic into 30-bit words (15 atoms), with the live fill state exported as dct_buffer/dct_count. Hands completed or flushed words downstream over a valid/ready interface, and owns the test_ending -> test_has_ended drain sequence seen by the OCI test bench.

Parameters:
ATOM_W, 2, bits per trace atom
ATOMS_PER_WORD, 15, atoms per packed word
BUF_W, 30, ATOM_W*ATOMS_PER_WORD; word width
CNT_W, 4, width of atom counts

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
atom_valid  in  1  trace atom present
atom  in  2  atom code
atom_ready  out  1  packer accepts atom this cycle
flush  in  1  single-cycle request to emit partial word
test_ending  in  1  level; end-of-test drain request
dct_buffer  out  30  live packing register
dct_count  out  4  atoms held in packing register, 0..14
out_valid  out  1  packed word available
out_data  out  30  packed word
out_count  out  4  valid atoms in out_data, 1..15
out_ready  in  1  downstream accepts word
test_has_ended  out  1  sticky; drain complete

Behaviour:
- Reset (async assert, sync deassert): dct_buffer=0, dct_count=0, out_valid=0, out_data=0, out_count=0, test_has_ended=0, flush_pend=0, ending=0. A reset mid-operation discards partial and held words.
- Accept: atom_valid && atom_ready. The atom is written to dct_buffer[2c+1:2c], where c=dct_count. Atom 0 is at the LSBs.
- out_free = !out_valid || out_ready (same-cycle pass-through allowed).
- Completion: an accept with c==14 moves the full word (accepted atom included) to the output register with out_count=15. Pack register and count then clear. Output latency is 1 cycle from the final accept.
- atom_ready = !ending && ((c != 14) || out_free). The packer stalls rather than dropping atoms.
- Flush: flush sets flush_pend. While flush_pend && out_free:
  - If c>0 (or an atom is accepted that cycle), emit the partial word with out_count equal to the resulting count. Bits above 2*out_count are zero. Then clear the pack register and flush_pend.
  - If c==0 and no accept, clear flush_pend and emit nothing.
- Simultaneous flush and accept: the atom is included in the flushed word. A flush arriving while flush_pend is already set is absorbed; no second empty word is emitted.
- Simultaneous flush and completion at c==14: one word with count 15.
- Output register: holds out_data/out_count stable while out_valid && !out_ready. Clears out_valid on handshake unless reloaded in the same cycle.
- test_ending: the first cycle it is high sets ending and flush_pend. Atoms in that same cycle are still accepted (atom_ready is evaluated before ending is set). From the next cycle atom_ready=0.
- test_has_ended: asserts one cycle after ending && c==0 && !flush_pend && !out_valid. Sticky until reset. test_ending deasserting after ending is set has no effect.
- State machine:
  - FILL: normal operation.
  - DRAIN: ending set, pending words outstanding.
  - DONE: test_has_ended=1.
  - Transitions: FILL->DRAIN on test_ending; DRAIN->DONE on the empty condition above. DONE exits only via reset.

Optional Feature:
OCI_DCT_STALL_CNT_EN
- Defined: adds output port stall_cnt [15:0]. It increments each cycle atom_valid && !atom_ready && !ending, saturates at 16'hFFFF, and resets to 0.
- Undefined: no port, no counter logic; behaviour otherwise identical.

Decomposition:
- Package nios2_oci_dct_pkg holds:
  - ATOM_W, ATOMS_PER_WORD, BUF_W, CNT_W.
  - Atom encoding typedef: 2'b00 NOP, 2'b01 TAKEN, 2'b10 NOT_TAKEN, 2'b11 EXCEPTION.
  - State enum {FILL, DRAIN, DONE}.
- One sub-module, nios2_oci_dct_outreg: one-entry valid/ready holding register for data+count, exposing out_free.

Test Plan:
- 15 accepted atoms 01 on consecutive cycles, out_ready=1 -> one cycle later out_valid=1, out_data=30'h15555555, out_count=15; dct_count returns 0.
- 3 atoms (11,10,01) then flush pulse -> out_data=30'h0000001B, out_count=3; flush with dct_count=0 -> no out_valid.
- out_ready=0 with a held word and 14 atoms packed -> atom_ready=0 at c=14. Raise out_ready -> held word handshakes and the 15th atom completes the next word in the same cycle.
- 5 atoms, test_ending raised with an atom in the same cycle -> word with out_count=6 emitted; atom_ready=0 afterwards; test_has_ended=1 one cycle after handshake, stays 1 after test_ending drops.
- reset_n low mid-word (dct_count=7, out_valid=1) -> all outputs 0 immediately (asynchronously); post-reset 15 atoms produce a clean word.
- With OCI_DCT_STALL_CNT_EN: hold atom_valid=1, out_ready=0 for 20 stalled cycles -> stall_cnt=20. Force 70000 stalls -> stall_cnt=16'hFFFF.
